// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit 5-stage CPU pipeline control blocks:
// FSM state encoding, default widths and multi-cycle counter helpers.
package cpu_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MC_BUSY = 1'b1
    } state_t;

    localparam int REG_AW_DEFAULT = 4;
    localparam int SIGNAL_FLUSH_W = 10;
    localparam int MC_CNT_W       = 4;

    // The start cycle and the release cycle are both outside MC_BUSY's countdown,
    // so the counter is loaded with L-2 and the release happens at zero.
    function automatic logic [MC_CNT_W-1:0] mc_reload(input int latency);
        if (latency > 1) begin
            return MC_CNT_W'(latency - 2);
        end
        return '0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment);
// used for the pipeline stall-cycle performance counter.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, ID-resolved branch squash,
// multi-cycle EX holds and a saturating stall-cycle counter.
module hazard_stall_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEFAULT,
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_branch_taken,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mc_start,
    input  logic              perf_clr,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_write,
    output logic              idex_bubble,
    output logic              exm_bubble,
    output logic              mc_busy,
    output logic              mc_done,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [MC_CNT_W-1:0] MC_RELOAD = mc_reload(MC_LATENCY);
    localparam bit                  MC_HOLDS  = (MC_LATENCY > 1);

    state_t              state;
    logic [MC_CNT_W-1:0] mc_cnt;
    logic                load_use;

    assign load_use = ex_mem_read & ex_reg_write &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) |
                       (id_use_rs2 & (id_rs2 == ex_rd)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_RUN;
            mc_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (ex_mc_start && MC_HOLDS) begin
                        state  <= ST_MC_BUSY;
                        mc_cnt <= MC_RELOAD;
                    end
                end
                ST_MC_BUSY: begin
                    if (mc_cnt != '0) begin
                        mc_cnt <= mc_cnt - MC_CNT_W'(1);
                    end else begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state  <= ST_RUN;
                    mc_cnt <= '0;
                end
            endcase
        end
    end

    // Reset drives the pipeline into a fully bubbled, frozen-PC condition.
    // A multi-cycle op outranks load-use since EX cannot hold both kinds of instruction.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_bubble = 1'b0;
        exm_bubble  = 1'b0;
        mc_busy     = 1'b0;
        mc_done     = 1'b0;
        if (!reset_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exm_bubble  = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (ex_mc_start) begin
                        mc_busy = 1'b1;
                        if (MC_HOLDS) begin
                            pc_write   = 1'b0;
                            ifid_write = 1'b0;
                            idex_write = 1'b0;
                            exm_bubble = 1'b1;
                        end else begin
                            mc_done    = 1'b1;
                            ifid_flush = id_branch_taken;
                        end
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (id_branch_taken) begin
                        ifid_flush = 1'b1;
                    end
                end
                ST_MC_BUSY: begin
                    mc_busy = 1'b1;
                    if (mc_cnt != '0) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_write = 1'b0;
                        exm_bubble = 1'b1;
                    end else begin
                        mc_done    = 1'b1;
                        ifid_flush = id_branch_taken;
                    end
                end
                default: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (perf_clr),
        .inc    (~pc_write),
        .count  (stall_cycles)
    );

endmodule
